// File: rtl/oled_spi_arbiter.sv
// Two-requester arbiter in front of one MSB-first OLED SPI byte serializer.
// Command bytes go out with dc=0, pixel bytes with dc=1. Define OLED_ARB_RR_EN for round-robin arbitration.
module oled_spi_arbiter #(
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_data,
    input  logic       cmd_last,
    output logic       cmd_ready,
    input  logic       pix_valid,
    input  logic [7:0] pix_data,
    input  logic       pix_last,
    output logic       pix_ready,
    output logic       cs,
    output logic       sdin,
    output logic       sclk,
    output logic       dc,
    output logic       busy,
    output logic       grant
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam logic [7:0] GAP_LAST = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] shreg_q, shreg_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] gap_cnt_q, gap_cnt_d;
    logic       last_q, last_d;
    logic       grant_q, grant_d;
    logic       dc_q, dc_d;
    logic       cs_q, cs_d;
    logic       sdin_q, sdin_d;
    logic       busy_q, busy_d;
`ifdef OLED_ARB_RR_EN
    logic       rr_q, rr_d;
`endif

    logic       any_req;
    logic       win_pix;
    logic       byte_done;
    logic       sel_pix;
    logic       sel_valid;
    logic [7:0] sel_data;
    logic       sel_last;
    logic       accept;
    logic       take;

    // Arbitration and accept window: in IDLE the arbiter picks, afterwards only the granted port is looked at.
    always_comb begin
        any_req = cmd_valid | pix_valid;
`ifdef OLED_ARB_RR_EN
        win_pix = pix_valid & (~cmd_valid | rr_q);
`else
        win_pix = pix_valid & ~cmd_valid;
`endif
        byte_done = (bit_cnt_q == 3'd0);
        sel_pix   = (state_q == IDLE) ? win_pix : grant_q;
        sel_valid = sel_pix ? pix_valid : cmd_valid;
        sel_data  = sel_pix ? pix_data  : cmd_data;
        sel_last  = sel_pix ? pix_last  : cmd_last;
        case (state_q)
            IDLE:    accept = any_req;
            SHIFT:   accept = byte_done & ~last_q;
            HOLD:    accept = 1'b1;
            default: accept = 1'b0;
        endcase
        take = accept & sel_valid & reset;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            shreg_q   <= 8'd0;
            bit_cnt_q <= 3'd0;
            gap_cnt_q <= 8'd0;
            last_q    <= 1'b0;
            grant_q   <= 1'b0;
            dc_q      <= 1'b0;
            cs_q      <= 1'b1;
            sdin_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef OLED_ARB_RR_EN
            rr_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            dc_q      <= dc_d;
            cs_q      <= cs_d;
            sdin_q    <= sdin_d;
            busy_q    <= busy_d;
`ifdef OLED_ARB_RR_EN
            rr_q      <= rr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (any_req) state_d = SHIFT;
            end
            SHIFT: begin
                if (byte_done) begin
                    if (!last_q)              state_d = take ? SHIFT : HOLD;
                    else if (GAP_CYCLES == 0) state_d = IDLE;
                    else                      state_d = GAP;
                end
            end
            HOLD: begin
                if (take) state_d = SHIFT;
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: sdin_q carries the bit on the wire, shreg_q the bits still to come.
    always_comb begin
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        last_d    = last_q;
        grant_d   = grant_q;
        dc_d      = dc_q;
        cs_d      = cs_q;
        sdin_d    = sdin_q;
`ifdef OLED_ARB_RR_EN
        rr_d      = rr_q;
`endif
        if (take) begin
            shreg_d   = {sel_data[6:0], 1'b0};
            sdin_d    = sel_data[7];
            bit_cnt_d = 3'd7;
            last_d    = sel_last;
            cs_d      = 1'b0;
            if (state_q == IDLE) begin
                grant_d = sel_pix;
                dc_d    = sel_pix;
            end
        end else begin
            case (state_q)
                SHIFT: begin
                    if (!byte_done) begin
                        sdin_d    = shreg_q[7];
                        shreg_d   = {shreg_q[6:0], 1'b0};
                        bit_cnt_d = bit_cnt_q - 3'd1;
                    end else begin
                        sdin_d = 1'b0;
                        if (last_q) begin
                            cs_d      = 1'b1;
                            gap_cnt_d = 8'd0;
                            last_d    = 1'b0;
`ifdef OLED_ARB_RR_EN
                            rr_d      = ~grant_q;
`endif
                        end
                    end
                end
                HOLD: begin
                    sdin_d = 1'b0;
                    cs_d   = 1'b0;
                end
                GAP: begin
                    cs_d      = 1'b1;
                    sdin_d    = 1'b0;
                    gap_cnt_d = (gap_cnt_q == GAP_LAST) ? 8'd0 : gap_cnt_q + 8'd1;
                end
                default: begin
                    cs_d   = 1'b1;
                    sdin_d = 1'b0;
                end
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    always_comb begin
        cmd_ready = reset & accept & ~sel_pix;
        pix_ready = reset & accept & sel_pix;
        cs        = cs_q;
        sdin      = sdin_q;
        sclk      = ~clock;
        dc        = dc_q;
        busy      = busy_q;
        grant     = grant_q;
    end

endmodule

// File: doc/oled_spi_arbiter.md
# oled_spi_arbiter

- Shares one OLED SPI byte serializer between two requesters.
  - Command requester: bytes sent with dc=0, e.g. power-up/shutdown sequencer.
  - Pixel requester: bytes sent with dc=1, e.g. framebuffer streamer.
- Grants one requester per burst, serializes each byte MSB-first, holds cs low for the whole burst and inserts a programmable idle gap between bursts.
- Sits between the OLED sequencing/streaming logic and the display pins.

## Interface

Parameters:
- GAP_CYCLES, 2, idle cycles with cs high after every burst (0–255).

Ports:
- clock  in  1  system clock; sclk is derived from it.
- reset  in  1  synchronous reset, active-low; all state clears on a rising clock edge with reset=0.
- cmd_valid  in  1  command byte available.
- cmd_data  in  8  command byte.
- cmd_last  in  1  byte is the final byte of its burst.
- cmd_ready  out  1  command byte accepted this cycle (valid && ready).
- pix_valid, pix_data[7:0], pix_last, pix_ready  same semantics for the pixel requester.
- cs  out  1  chip select, active low.
- sdin  out  1  serial data, MSB first.
- sclk  out  1  equals ~clock.
- dc  out  1  0 = command burst, 1 = pixel burst.
- busy  out  1  high in any state other than IDLE.
- grant  out  1  0 = command owns the bus, 1 = pixel owns the bus; meaningful while busy.

## Operation

- Reset values: cs=1, sdin=0, dc=0, busy=0, grant=0, cmd_ready=0, pix_ready=0; state=IDLE; shift register, bit counter, gap counter and last flag all 0.
- States are IDLE, SHIFT, HOLD and GAP.
- IDLE:
  - If either valid is high, pick a winner (see Configuration).
  - The winner's ready is asserted combinationally that cycle.
  - Capture data into the shift register and the last flag; set grant and dc; go to SHIFT with bit counter 7.
- SHIFT:
  - cs=0 and sdin = shreg[7]; shift left once per cycle.
  - After 8 cycles (bit counter = 0):
    - Last flag = 0: the granted port's ready is high. If the granted valid is high, capture the next byte and stay in SHIFT with no bubble. Otherwise go to HOLD.
    - Last flag = 1: go to GAP, or to IDLE if GAP_CYCLES=0.
- HOLD:
  - cs stays low, sdin=0, granted ready is high.
  - The non-granted requester is never served, even if its valid is high.
  - On granted valid: capture and go to SHIFT.
- GAP: cs=1; count GAP_CYCLES cycles, then go to IDLE.
- ready is high only for the granted port, only in an accepting cycle. The other port's ready stays 0 for the whole burst.
- dc and grant are constant from capture of a burst's first byte until the next burst's first capture.
- Reset low mid-burst: the next edge forces all reset values, including cs=1. The partial byte is discarded and no ready is asserted in that cycle.
- cmd_last or pix_last while in HOLD/SHIFT has effect only on the byte actually captured.

## Timing

- Capture cycle C: the first bit (data[7]) is on sdin in cycles C+1..; data[0] is on sdin in cycle C+8.
- A burst of N bytes with continuous valid occupies N*8 SHIFT cycles, followed by GAP_CYCLES cycles of cs=1.
- The next grant is possible at the earliest in the cycle after GAP ends (IDLE cycle). Minimum turnaround is GAP_CYCLES+1 cycles with cs high.
- sclk = ~clock, so the display samples sdin on the falling edge of clock, mid-bit.
- All outputs except the ready signals and sclk are registered.

## Configuration

- OLED_ARB_RR_EN defined: round-robin arbitration.
  - A priority pointer flips after each completed burst: command-last gives pixel priority, pixel-last gives command priority.
  - The pointer resets to command priority.
  - A sole requester always wins.
- OLED_ARB_RR_EN undefined: fixed priority; command always wins a simultaneous request. No pointer register exists.

## Test plan

- Single command byte 0xAE with cmd_last=1, GAP_CYCLES=2:
  - cmd_ready pulses once; cs low for exactly 8 cycles; sdin = 1,0,1,0,1,1,1,0; dc=0; cs high for 2 cycles; then busy=0.
- Command burst 0x8D then 0x14, valid continuous:
  - cs low for exactly 16 contiguous cycles; sdin shows 0x8D then 0x14 with no bubble; cmd_ready high at the capture cycle and at cycle C+8.
- Pixel burst 0xFF (last=0), then pix_valid dropped for 5 cycles, then 0x00 (last=1):
  - 5 HOLD cycles with cs=0 and dc=1; a cmd_valid asserted during HOLD gets no cmd_ready until after GAP.
- cmd_valid and pix_valid both high in IDLE, one-byte bursts each, requests held:
  - Without OLED_ARB_RR_EN: grant sequence is cmd, cmd, cmd, ...
  - With OLED_ARB_RR_EN: grant sequence is cmd, pix, cmd, pix.
- GAP_CYCLES=0, two back-to-back single-byte command bursts:
  - Exactly one cs=1 cycle (IDLE) between the bursts.
- Reset driven low at bit 3 of a byte:
  - Next edge gives cs=1, sdin=0, busy=0, readies 0.
  - After release, a new cmd byte 0xAF serializes completely from bit 7.
